peak_meter: RTL and testbench
=============================

Name: peak_meter

Overview:
- Multi-channel peak-hold level meter with decay, replacing the single-channel instantaneous abs-value LED meter in the mixer top.
- Sits on the ADAT input side, sampling the input decoder's audio bus on its data-valid strobe. Drives per-channel meter levels, clip flags and a frame-done strobe toward LEDs and the control interface.
- Channels are processed serially, one per clock, through a single shared abs/compare/decay datapath.

Parameters:
- NUM_CHANNELS, 8: channels on audio_bus; must be ≥1.
- SAMPLE_WIDTH, 24: signed sample width.
- METER_WIDTH, 8: meter output width; must be ≤ SAMPLE_WIDTH-1.
- HOLD_FRAMES, 4: frames the peak is held before decay starts; 0 means decay on the next frame.
- DECAY_SHIFT, 3: per-frame decay step is peak >> DECAY_SHIFT, minimum 1.
- CLIP_THRESHOLD, 2**(SAMPLE_WIDTH-1)-1: magnitude at or above which clip is flagged.

Ports:
- clk, in, 1: system clock (oversampling domain).
- rst, in, 1: asynchronous, active-high reset.
- data_valid, in, 1: one-cycle frame strobe; audio_bus is valid in the same cycle.
- audio_bus, in, NUM_CHANNELS x SAMPLE_WIDTH signed: input frame.
- clear, in, 1: synchronous clear of the sticky flags (clip, overrun).
- busy, out, 1: scan in progress.
- frame_done, out, 1: one-cycle pulse when a scan completes.
- meter_level, out, NUM_CHANNELS x METER_WIDTH: per-channel meter value.
- clip, out, NUM_CHANNELS: sticky per-channel clip flags.
- overrun, out, 1: sticky flag, set when a frame is dropped.

Behaviour:
- Reset (asynchronous, any state, including mid-scan) clears everything and returns the FSM to IDLE. Every output, peak register and hold counter is 0.
- States:
  - IDLE: data_valid latches all of audio_bus into a frame buffer, sets idx=0, moves to SCAN, and drives busy=1 from the next cycle.
  - SCAN: each cycle processes channel idx from the buffer.
    - If idx<N-1: idx++.
    - If idx==N-1: frame_done=1 for one cycle, registered on the same edge as the last channel update.
    - Then, if data_valid is high in that last cycle: the frame is accepted, a new scan starts at idx=0, and busy stays 1. Otherwise return to IDLE with busy=0.
- data_valid in any SCAN cycle other than the last drops the frame and sets overrun. Buffered data is never overwritten mid-scan.
- Latency: data_valid at cycle 0 gives channel k updated at the edge ending cycle k+1. frame_done is high in cycle N+1 relative to that strobe.
- Magnitude:
  - mag = |sample|, held in SAMPLE_WIDTH-1 bits.
  - The most-negative code saturates to 2**(SAMPLE_WIDTH-1)-1.
- Peak/hold/decay, per channel per frame:
  - If mag > peak: peak=mag and hold=HOLD_FRAMES.
  - Else, if hold≠0: hold--.
  - Else: dec = max(peak>>DECAY_SHIFT, 1) when peak≠0, else 0; peak = max(peak-dec, mag).
  - No underflow: peak saturates at 0.
- meter_level[k] = peak[k][SAMPLE_WIDTH-2 -: METER_WIDTH], registered. It updates only when channel k is processed.
- Hold counter width: $clog2(HOLD_FRAMES+1), minimum 1.
- clear and a simultaneous set event in the same cycle: set wins.

Optional Feature:
- Macro: PEAK_METER_CLIP_EN.
- Defined:
  - clip[k] is set when mag ≥ CLIP_THRESHOLD during channel k's scan cycle.
  - clip[k] is sticky until clear.
- Undefined:
  - clip is tied to 0, with no clip registers or comparator.
  - clear still clears overrun.

Test Plan (N=8, W=24, METER_WIDTH=8, HOLD_FRAMES=4, DECAY_SHIFT=3):
- Reset: assert rst mid-scan, release → meter_level all 0x00, clip=0, overrun=0, busy=0, frame_done=0. The next data_valid starts a scan at channel 0.
- Peak capture: frame with ch0=0x400000, all others 0 → busy high for 8 cycles, frame_done pulse in cycle 9, meter_level[0]=0x80, all other channels 0x00.
- Hold and decay: continuing from the previous case, 5 all-zero frames → frames 1–4 keep meter_level[0]=0x80. Frame 5 gives peak 0x380000 and meter_level[0]=0x70. A further frame with ch0=0x390000 gives peak 0x390000 (max rule), hold reloaded.
- Clip (macro defined): ch3=0x800000 → peak[3]=0x7FFFFF, meter_level[3]=0xFF, clip[3]=1. clip stays 1 over 3 quiet frames. clear pulse → clip[3]=0. clear coincident with a new ch3=0x7FFFFF scan cycle → clip[3] stays 1.
- Overrun and back-to-back:
  - data_valid in scan cycle 3 → overrun=1, that frame is dropped, meter values unaffected.
  - data_valid in scan cycle 8 (last) → accepted, busy stays 1, a second frame_done follows 8 cycles later, overrun unchanged.
- Macro undefined: ch0=0x800000 → meter_level[0]=0xFF, clip stays 0.

Source files
------------

// File: rtl/peak_meter.sv
// -----------------------------------------------------------------------------
// peak_meter
//   Multi-channel peak-hold level meter with per-frame decay. A frame strobed
//   by data_valid is captured into a buffer and then scanned one channel per
//   clock through a single shared abs / compare / hold / decay datapath.
//
//   Optional feature macro: PEAK_METER_CLIP_EN
//     defined   : sticky per-channel clip flags (mag >= CLIP_THRESHOLD)
//     undefined : clip is tied to 0 and no clip logic is built
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   data_valid  in   one-cycle frame strobe, audio_bus valid in the same cycle
//   audio_bus   in   NUM_CHANNELS x SAMPLE_WIDTH signed samples, ch0 in LSBs
//   clear       in   synchronous clear of sticky flags (clip, overrun)
//   busy        out  scan in progress
//   frame_done  out  one-cycle pulse when the last channel has been updated
//   meter_level out  NUM_CHANNELS x METER_WIDTH meter values, ch0 in LSBs
//   clip        out  sticky per-channel clip flags
//   overrun     out  sticky flag, set when a frame is dropped
// -----------------------------------------------------------------------------
module peak_meter #(
    parameter int NUM_CHANNELS = 8,
    parameter int SAMPLE_WIDTH = 24,
    parameter int METER_WIDTH  = 8,
    parameter int HOLD_FRAMES  = 4,
    parameter int DECAY_SHIFT  = 3,
    parameter logic [SAMPLE_WIDTH-2:0] CLIP_THRESHOLD = {(SAMPLE_WIDTH-1){1'b1}}
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 data_valid,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] audio_bus,
    input  logic                                 clear,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic [NUM_CHANNELS*METER_WIDTH-1:0]  meter_level,
    output logic [NUM_CHANNELS-1:0]              clip,
    output logic                                 overrun
);

    localparam int MW = SAMPLE_WIDTH - 1;  // magnitude / peak width
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CHANNELS - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);

    typedef enum logic {IDLE, SCAN} state_t;

    // |s| in MW bits; the most-negative code has no positive twin and
    // saturates to full scale.
    function automatic logic [MW-1:0] abs_sat(input logic signed [SAMPLE_WIDTH-1:0] s);
        logic signed [SAMPLE_WIDTH-1:0] neg;
        neg = -s;
        if (!s[SAMPLE_WIDTH-1]) return s[MW-1:0];
        if (s[MW-1:0] == '0) return {MW{1'b1}};
        return neg[MW-1:0];
    endfunction

    // One decay step: subtract max(pk >> DECAY_SHIFT, 1), floor at 0.
    function automatic logic [MW-1:0] decay_step(input logic [MW-1:0] pk);
        logic [MW-1:0] dec;
        dec = pk >> DECAY_SHIFT;
        if (dec == '0 && pk != '0) dec = MW'(1);
        return (pk > dec) ? (pk - dec) : '0;
    endfunction

    state_t                          state_q;
    logic [IW-1:0]                   idx_q;
    logic                            busy_q;
    logic                            frame_done_q;
    logic                            overrun_q;
    logic signed [SAMPLE_WIDTH-1:0]  frame_q [NUM_CHANNELS];
    logic signed [SAMPLE_WIDTH-1:0]  frame_d [NUM_CHANNELS];
    logic [MW-1:0]                   peak_q  [NUM_CHANNELS];
    logic [HW-1:0]                   hold_q  [NUM_CHANNELS];
    logic [METER_WIDTH-1:0]          meter_q [NUM_CHANNELS];

    logic signed [SAMPLE_WIDTH-1:0]  samp;
    logic [MW-1:0]                   mag;
    logic [MW-1:0]                   peak_cur;
    logic [MW-1:0]                   decayed;
    logic [MW-1:0]                   peak_d;
    logic [HW-1:0]                   hold_cur;
    logic [HW-1:0]                   hold_d;

    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            frame_d[k] = $signed(audio_bus[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        end
    end

    // Shared per-channel datapath for the channel currently being scanned.
    always_comb begin
        samp     = frame_q[idx_q];
        mag      = abs_sat(samp);
        peak_cur = peak_q[idx_q];
        hold_cur = hold_q[idx_q];
        decayed  = decay_step(peak_cur);
        peak_d   = peak_cur;
        hold_d   = hold_cur;
        if (mag > peak_cur) begin
            peak_d = mag;
            hold_d = HOLD_INIT;
        end else if (hold_cur != '0) begin
            hold_d = hold_cur - HW'(1);
        end else begin
            // A fresh sample can still beat the decayed value.
            peak_d = (decayed > mag) ? decayed : mag;
        end
    end

`ifdef PEAK_METER_CLIP_EN
    logic [NUM_CHANNELS-1:0] clip_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                frame_q[k] <= '0;
                peak_q[k]  <= '0;
                hold_q[k]  <= '0;
                meter_q[k] <= '0;
            end
`ifdef PEAK_METER_CLIP_EN
            clip_q       <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            // Clears come first so that a set later in this block wins.
            if (clear) overrun_q <= 1'b0;
`ifdef PEAK_METER_CLIP_EN
            if (clear) clip_q <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        frame_q <= frame_d;
                        idx_q   <= '0;
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    peak_q[idx_q]  <= peak_d;
                    hold_q[idx_q]  <= hold_d;
                    meter_q[idx_q] <= peak_d[MW-1 -: METER_WIDTH];
`ifdef PEAK_METER_CLIP_EN
                    if (mag >= CLIP_THRESHOLD) clip_q[idx_q] <= 1'b1;
`endif
                    if (idx_q == LAST_IDX) begin
                        frame_done_q <= 1'b1;
                        // A strobe in the last scan cycle chains straight into
                        // the next scan; the buffer is free from the next edge.
                        if (data_valid) begin
                            frame_q <= frame_d;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        idx_q <= idx_q + IW'(1);
                        if (data_valid) overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

    always_comb begin
        meter_level = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            meter_level[k*METER_WIDTH +: METER_WIDTH] = meter_q[k];
        end
    end

`ifdef PEAK_METER_CLIP_EN
    assign clip = clip_q;
`else
    logic unused_clip_thr;
    assign unused_clip_thr = ^CLIP_THRESHOLD;
    assign clip = '0;
`endif

endmodule

// File: tb/tb_peak_meter.sv
module tb_peak_meter;

    localparam int N  = 8;
    localparam int W  = 24;
    localparam int MW = 8;
    localparam int BW = N * W;
    localparam int MAXMAG = 8388607;  // 2**23-1

    logic            clk;
    logic            rst;
    logic            data_valid;
    logic [BW-1:0]   audio_bus;
    logic            clear;
    logic            busy;
    logic            frame_done;
    logic [N*MW-1:0] meter_level;
    logic [N-1:0]    clip;
    logic            overrun;

    int errors = 0;
    int checks = 0;

    // Reference model state and scoreboard of {clip, meter_level} per frame.
    int          pk [N];
    int          hd [N];
    logic [N-1:0] clp;
    logic [71:0] sb_q [$];

    peak_meter #(
        .NUM_CHANNELS(N),
        .SAMPLE_WIDTH(W),
        .METER_WIDTH (MW),
        .HOLD_FRAMES (4),
        .DECAY_SHIFT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .audio_bus  (audio_bus),
        .clear      (clear),
        .busy       (busy),
        .frame_done (frame_done),
        .meter_level(meter_level),
        .clip       (clip),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input int ch, input logic [W-1:0] v);
        logic [BW-1:0] b;
        b = '0;
        b[ch*W +: W] = v;
        return b;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            pk[k] = 0;
            hd[k] = 0;
        end
        clp = '0;
    endfunction

    function automatic void model_clear();
        clp = '0;
    endfunction

    function automatic void model_frame(input logic [BW-1:0] bus);
        logic [63:0] m;
        for (int k = 0; k < N; k++) begin
            logic signed [W-1:0] s24;
            int s;
            int mag;
            int dec;
            s24 = bus[k*W +: W];
            s   = s24;
            mag = (s < 0) ? -s : s;
            if (mag > MAXMAG) mag = MAXMAG;
            if (mag > pk[k]) begin
                pk[k] = mag;
                hd[k] = 4;
            end else if (hd[k] != 0) begin
                hd[k] = hd[k] - 1;
            end else begin
                dec = pk[k] >> 3;
                if (pk[k] != 0 && dec == 0) dec = 1;
                pk[k] = (pk[k] > dec) ? pk[k] - dec : 0;
                if (mag > pk[k]) pk[k] = mag;
            end
`ifdef PEAK_METER_CLIP_EN
            if (mag >= MAXMAG) clp[k] = 1'b1;
`endif
            m[k*8 +: 8] = 8'(pk[k] >> 15);
        end
        sb_q.push_back({clp, m});
    endfunction

    task automatic pop_compare(input string tag);
        logic [71:0] e;
        chk({tag, "_sb_avail"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_meter"}, meter_level, e[63:0]);
            chk({tag, "_clip"}, 64'(clip), 64'(e[71:64]));
        end
    endtask

    // Leaves the bench in scan cycle 1 of the new frame.
    task automatic start_frame(input string tag, input logic [BW-1:0] bus);
        data_valid = 1'b1;
        audio_bus  = bus;
        model_frame(bus);
        tick();
        data_valid = 1'b0;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        chk({tag, "_fd_start"}, 64'(frame_done), 64'd0);
    endtask

    // Waits (bounded) for frame_done, counting cycles from n0 and busy cycles.
    task automatic wait_done(input string tag, input int n0, output int n, output int bcnt);
        n = n0;
        bcnt = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bcnt++;
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(frame_done), 64'd1);
        pop_compare(tag);
    endtask

    task automatic run_frame(input string tag, input logic [BW-1:0] bus);
        int n;
        int b;
        start_frame(tag, bus);
        wait_done(tag, 1, n, b);
        chk({tag, "_latency"}, 64'(n), 64'd9);
        chk({tag, "_busy_cycles"}, 64'(b), 64'd8);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        int b;
        rst        = 1'b1;
        data_valid = 1'b0;
        audio_bus  = '0;
        clear      = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_meter", meter_level, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // Reset asserted mid-scan clears everything asynchronously.
        data_valid = 1'b1;
        audio_bus  = mk(0, 24'h800000);
        tick();
        data_valid = 1'b0;
        tick();
        tick();
        chk("midscan_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        chk("arst_meter", meter_level, 64'd0);
        chk("arst_clip", 64'(clip), 64'd0);
        chk("arst_overrun", 64'(overrun), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_fd", 64'(frame_done), 64'd0);
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Peak capture.
        run_frame("cap", mk(0, 24'h400000));
        chk("cap_const", meter_level, 64'h80);

        // Hold for four frames, then decay.
        for (int i = 0; i < 4; i++) begin
            run_frame("hold", '0);
            chk("hold_const", 64'(meter_level[7:0]), 64'h80);
        end
        run_frame("decay", '0);
        chk("decay_const", 64'(meter_level[7:0]), 64'h70);
        run_frame("maxrule", mk(0, 24'h390000));
        chk("maxrule_const", 64'(meter_level[7:0]), 64'h72);
        run_frame("reload", '0);
        chk("reload_const", 64'(meter_level[7:0]), 64'h72);

`ifdef PEAK_METER_CLIP_EN
        run_frame("clip", mk(3, 24'h800000));
        chk("clip_meter3", 64'(meter_level[31:24]), 64'hFF);
        chk("clip_flag", 64'(clip), 64'h08);
        for (int i = 0; i < 3; i++) begin
            run_frame("clip_quiet", '0);
            chk("clip_sticky", 64'(clip), 64'h08);
        end
        clear = 1'b1;
        model_clear();
        tick();
        clear = 1'b0;
        chk("clip_cleared", 64'(clip), 64'h00);
        model_clear();
        start_frame("coinc", mk(3, 24'h7FFFFF));
        tick();
        tick();
        tick();
        clear = 1'b1;  // scan cycle 4 processes channel 3
        tick();
        clear = 1'b0;
        chk("coinc_set_wins", 64'(clip), 64'h08);
        wait_done("coinc", 5, n, b);
        chk("coinc_latency", 64'(n), 64'd9);
`else
        run_frame("noclip", mk(0, 24'h800000));
        chk("noclip_meter0", 64'(meter_level[7:0]), 64'hFF);
        chk("noclip_flag", 64'(clip), 64'h00);
`endif

        // Back-to-back: strobe in the last scan cycle is accepted.
        chk("pre_b2b_overrun", 64'(overrun), 64'd0);
        start_frame("b2b1", mk(6, 24'h200000));
        for (int i = 0; i < 7; i++) tick();
        data_valid = 1'b1;
        audio_bus  = mk(1, 24'h300000);
        model_frame(audio_bus);
        tick();
        data_valid = 1'b0;
        chk("b2b_fd1", 64'(frame_done), 64'd1);
        chk("b2b_busy_kept", 64'(busy), 64'd1);
        pop_compare("b2b1");
        tick();
        wait_done("b2b2", 2, n, b);
        chk("b2b2_latency", 64'(n), 64'd9);
        chk("b2b2_busy_cycles", 64'(b), 64'd7);
        chk("b2b2_busy_end", 64'(busy), 64'd0);
        chk("b2b_overrun", 64'(overrun), 64'd0);

        // Overrun: strobe in scan cycle 3 is dropped.
        start_frame("ovr", mk(5, 24'h100000));
        tick();
        tick();
        data_valid = 1'b1;
        audio_bus  = mk(5, 24'h7FFFFF);
        tick();
        data_valid = 1'b0;
        chk("ovr_set", 64'(overrun), 64'd1);
        wait_done("ovr", 4, n, b);
        chk("ovr_latency", 64'(n), 64'd9);
        chk("ovr_meter5", 64'(meter_level[47:40]), 64'h20);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        tick();
        chk("ovr_no_restart", 64'(busy), 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ovr_cleared", 64'(overrun), 64'd0);

        // clear coincident with a drop: set wins.
        start_frame("ovr2", '0);
        tick();
        tick();
        data_valid = 1'b1;
        clear      = 1'b1;
        tick();
        data_valid = 1'b0;
        clear      = 1'b0;
        chk("ovr2_set_wins", 64'(overrun), 64'd1);
        wait_done("ovr2", 4, n, b);
        chk("ovr2_latency", 64'(n), 64'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
